// File: rtl/fp_sqr_arbiter_pkg.sv
// Shared constants and exception encodings for the FP(8,23) squarer arbiter.
package fp_sqr_arb_pkg;

    localparam int FP_W = 34;
    localparam int WE   = 8;
    localparam int WF   = 23;
    localparam int BIAS = 127;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_t;

endpackage

// File: rtl/fp_sqr_arbiter_if.sv
// Requester and response bundle between activation units and the shared squarer.
interface fp_sqr_arbiter_if
    import fp_sqr_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][FP_W-1:0] req_data;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [FP_W-1:0]        resp_data;
    logic [IDW-1:0]         resp_id;
    logic                   busy;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/fp_sqr_arbiter_pipe.sv
// Combinational FP(8,23) squarer followed by LAT register stages carrying valid/id/data.
module FPsqr
    import fp_sqr_arb_pkg::*;
(
    input  logic [FP_W-1:0] X,
    output logic [FP_W-1:0] R
);
    logic [WF:0]        mant;
    logic [2*WF+1:0]    prod;
    logic [WF-1:0]      frac;
    logic               guard, sticky, rnd;
    logic [WE+2:0]      ex;
    logic [WE+WF+2:0]   sum;
    logic               unused_sign;

    // Squares are always non-negative, so the input sign never matters.
    assign unused_sign = X[WE+WF];

    always_comb begin
        mant = {1'b1, X[WF-1:0]};
        prod = mant * mant;
        if (prod[2*WF+1]) begin
            frac   = prod[2*WF:WF+1];
            guard  = prod[WF];
            sticky = |prod[WF-1:0];
        end else begin
            frac   = prod[2*WF-1:WF];
            guard  = prod[WF-1];
            sticky = |prod[WF-2:0];
        end
        rnd = guard & (sticky | frac[0]);
        // Signed 11-bit exponent; rounding carry ripples from the fraction into it.
        ex  = {2'b00, X[WE+WF-1:WF], 1'b0} - (WE+3)'(BIAS) + (WE+3)'(prod[2*WF+1]);
        sum = {ex, frac} + (WE+WF+3)'(rnd);
        R   = '0;
        case (exc_t'(X[FP_W-1:FP_W-2]))
            EXC_NORMAL: begin
                if (sum[WE+WF+2])
                    R = '0;
                else if (|sum[WE+WF+1:WE+WF])
                    R = {EXC_INF, (FP_W-2)'(0)};
                else
                    R = {EXC_NORMAL, 1'b0, sum[WE+WF-1:0]};
            end
            EXC_INF: R = {EXC_INF, (FP_W-2)'(0)};
            EXC_NAN: R = {EXC_NAN, (FP_W-2)'(0)};
            default: R = '0;
        endcase
    end
endmodule

module fp_sqr_pipe
    import fp_sqr_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int IDW = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IDW-1:0]  in_id,
    input  logic [FP_W-1:0] in_data,
    output logic            out_valid,
    output logic [IDW-1:0]  out_id,
    output logic [FP_W-1:0] out_data
);
    localparam int STAGES = LAT - 1;

    logic [FP_W-1:0]              sq;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0][IDW-1:0]     id_pipe;
    logic [STAGES:0][FP_W-1:0]    dat_pipe;

    FPsqr u_sqr (.X(in_data), .R(sq));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        id_pipe[0]  <= in_id;
        dat_pipe[0] <= sq;
        for (int k = 1; k <= STAGES; k++) begin
            id_pipe[k]  <= id_pipe[k-1];
            dat_pipe[k] <= dat_pipe[k-1];
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_id    = id_pipe[STAGES];
    assign out_data  = dat_pipe[STAGES];
endmodule

// File: rtl/fp_sqr_arbiter.sv
// Round-robin, credit-limited front end sharing one squarer pipe among N requesters.
// Define FP_SQR_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module fp_sqr_arbiter
    import fp_sqr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int IDW   = 2
)(
    input  logic clk,
    input  logic rst,
    fp_sqr_arbiter_if.slave bus
`ifdef FP_SQR_ARB_STATS_EN
    ,
    output logic [N*16-1:0] grant_cnt
`endif
);
    // DEPTH must be a power of two so the wrapping pointers index the FIFO directly.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [FP_W-1:0] data;
    } resp_t;

    logic [IDW-1:0]  rr, gnt_id, idx;
    logic [N-1:0]    grant;
    logic            found, can_issue, issue, pop;
    logic [CW-1:0]   cnt;
    int              s;

    logic            pipe_vld;
    logic [IDW-1:0]  pipe_id;
    logic [FP_W-1:0] pipe_data;

    resp_t           mem [DEPTH];
    logic [AW:0]     wptr, rptr;
    logic            empty, full, wr_en;

    // Credits cover in-flight plus buffered results, so a grant implies a FIFO slot.
    assign can_issue = !rst && (cnt < CW'(DEPTH));

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        s      = 0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(rr) + k;
            if (s >= N) s = s - N;
            idx = IDW'(s);
            if (can_issue && !found && bus.req_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_id     = idx;
                found      = 1'b1;
            end
        end
    end

    assign issue         = found;
    assign pop           = bus.resp_valid && bus.resp_ready;
    assign bus.req_ready = grant;
    assign bus.busy      = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr  <= '0;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(issue) - CW'(pop);
            if (issue) rr <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    fp_sqr_pipe #(.LAT(LAT), .IDW(IDW)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_id     (gnt_id),
        .in_data   (bus.req_data[gnt_id]),
        .out_valid (pipe_vld),
        .out_id    (pipe_id),
        .out_data  (pipe_data)
    );

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_en = pipe_vld && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= '{id: pipe_id, data: pipe_data};
    end

    // Zeroed outputs while empty keep the bus quiet after reset and between bursts.
    assign bus.resp_valid = !empty;
    assign bus.resp_data  = empty ? '0 : mem[rptr[AW-1:0]].data;
    assign bus.resp_id    = empty ? '0 : mem[rptr[AW-1:0]].id;

`ifdef FP_SQR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule
